// File: rtl/vblank_scheduler.sv
// Round-robin arbiter that hands out the vertical-blanking window to game-logic
// requesters, one grant per requester per frame, with slot timeout and miss reporting.
module vblank_scheduler #(
    parameter int N_REQ        = 4,
    parameter int MAX_SLOT_CYC = 4096,
    parameter int GUARD_LINES  = 2,
    parameter int V_COUNT_TOT  = 806
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [10:0]              vcount,
    input  logic                     vblnk,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         done,
    output logic [N_REQ-1:0]         gnt,
    output logic                     frame_tick,
    output logic                     window_open,
    output logic                     overrun,
    output logic [$clog2(N_REQ)-1:0] ovr_id,
    output logic [N_REQ-1:0]         missed,
    output logic [15:0]              frame_cnt
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int CW     = IDX_W + 1;
    localparam int SLOT_W = $clog2(MAX_SLOT_CYC);
    localparam logic [10:0]       GUARD_START = 11'(V_COUNT_TOT - GUARD_LINES);
    localparam logic [SLOT_W-1:0] SLOT_LAST   = SLOT_W'(MAX_SLOT_CYC - 1);
    localparam logic [N_REQ-1:0]  ONE         = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, ARB, GRANT, CLOSE} state_t;

    state_t             state, state_nxt;
    logic               vblnk_d;
    logic [IDX_W-1:0]   gnt_idx, gnt_idx_nxt;
    logic [N_REQ-1:0]   served, served_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [SLOT_W-1:0]  slot_cnt, slot_nxt;
    logic [N_REQ-1:0]   gnt_nxt, missed_nxt;
    logic               frame_tick_nxt, window_open_nxt, overrun_nxt;
    logic [IDX_W-1:0]   ovr_id_nxt;
    logic [15:0]        frame_cnt_nxt;

    logic               open_evt, win_ok, pick_valid;
    logic [N_REQ-1:0]   eligible;
    logic [IDX_W-1:0]   pick;
    logic [CW-1:0]      cand;

    assign open_evt = vblnk & ~vblnk_d;
    // Uses the live vcount so a request arriving on the first guard line is already refused.
    assign win_ok   = window_open & vblnk & (vcount < GUARD_START);
    assign eligible = req & ~served;

    // Descending scan so the candidate closest after the pointer is the one that sticks.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        cand       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + CW'(k);
            if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
            if (eligible[cand[IDX_W-1:0]]) begin
                pick       = cand[IDX_W-1:0];
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        gnt_nxt         = gnt;
        gnt_idx_nxt     = gnt_idx;
        served_nxt      = served;
        ptr_nxt         = ptr;
        slot_nxt        = slot_cnt;
        frame_tick_nxt  = 1'b0;
        overrun_nxt     = 1'b0;
        ovr_id_nxt      = ovr_id;
        missed_nxt      = missed;
        frame_cnt_nxt   = frame_cnt;
        window_open_nxt = window_open & vblnk & (vcount < GUARD_START);

        case (state)
            ARB: begin
                if (!win_ok) begin
                    state_nxt = CLOSE;
                end else if (pick_valid) begin
                    gnt_nxt     = ONE << pick;
                    gnt_idx_nxt = pick;
                    slot_nxt    = '0;
                    state_nxt   = GRANT;
                end
            end
            GRANT: begin
                slot_nxt = slot_cnt + 1'b1;
                // done wins over timeout and over blanking end; either of the latter alone is a forced release.
                if (done[gnt_idx] || !vblnk || slot_cnt == SLOT_LAST) begin
                    gnt_nxt             = '0;
                    served_nxt[gnt_idx] = 1'b1;
                    ptr_nxt             = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
                    slot_nxt            = '0;
                    state_nxt           = vblnk ? ARB : CLOSE;
                    if (!done[gnt_idx]) begin
                        overrun_nxt = 1'b1;
                        ovr_id_nxt  = gnt_idx;
                    end
                end
            end
            CLOSE: begin
                if (!vblnk) begin
                    missed_nxt = req & ~served;
                    state_nxt  = IDLE;
                end
            end
            default: ;
        endcase

        if (open_evt && state != GRANT) begin
            frame_tick_nxt  = 1'b1;
            frame_cnt_nxt   = frame_cnt + 16'd1;
            served_nxt      = '0;
            window_open_nxt = 1'b1;
            state_nxt       = ARB;
        end
    end

    // vblnk_d resets high so a blanking interval already in progress at reset is not treated as a new frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            vblnk_d     <= 1'b1;
            gnt         <= '0;
            gnt_idx     <= '0;
            served      <= '0;
            ptr         <= '0;
            slot_cnt    <= '0;
            frame_tick  <= 1'b0;
            window_open <= 1'b0;
            overrun     <= 1'b0;
            ovr_id      <= '0;
            missed      <= '0;
            frame_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            vblnk_d     <= vblnk;
            gnt         <= gnt_nxt;
            gnt_idx     <= gnt_idx_nxt;
            served      <= served_nxt;
            ptr         <= ptr_nxt;
            slot_cnt    <= slot_nxt;
            frame_tick  <= frame_tick_nxt;
            window_open <= window_open_nxt;
            overrun     <= overrun_nxt;
            ovr_id      <= ovr_id_nxt;
            missed      <= missed_nxt;
            frame_cnt   <= frame_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_vblank_scheduler.sv
// Directed bench for vblank_scheduler: each scenario task drives the timing inputs
// and compares outputs against hand-derived values, sampling on the falling edge.
module tb_vblank_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] vcount;
    logic        vblnk;
    logic [3:0]  req;
    logic [3:0]  done;
    logic [3:0]  gnt;
    logic        frame_tick;
    logic        window_open;
    logic        overrun;
    logic [1:0]  ovr_id;
    logic [3:0]  missed;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_frames = 0;

    vblank_scheduler #(
        .N_REQ(4), .MAX_SLOT_CYC(4096), .GUARD_LINES(2), .V_COUNT_TOT(806)
    ) dut (
        .clk(clk), .rst(rst), .vcount(vcount), .vblnk(vblnk), .req(req), .done(done),
        .gnt(gnt), .frame_tick(frame_tick), .window_open(window_open), .overrun(overrun),
        .ovr_id(ovr_id), .missed(missed), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Rising edge of vblnk; returns on the falling edge where frame_tick is visible.
    task automatic start_frame();
        vblnk = 1'b0; vcount = 11'd767;
        tick(2);
        vblnk = 1'b1; vcount = 11'd768;
        tick(1);
        exp_frames++;
    endtask

    task automatic end_frame();
        vblnk = 1'b0; vcount = 11'd0;
        tick(3);
    endtask

    task automatic test_reset();
        rst = 1'b0; vblnk = 1'b1; vcount = 11'd770; req = 4'b0000; done = 4'b0000;
        tick(3);
        n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        n_checks++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
        n_checks++; if (window_open !== 1'b0 || frame_tick !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got wo=%b ft=%b ov=%b want 0 0 0", window_open, frame_tick, overrun); end
        n_checks++; if (missed !== 4'b0000 || ovr_id !== 2'd0) begin n_fail++; $display("FAIL reset_missed: got %b id=%0d want 0000 0", missed, ovr_id); end
        rst = 1'b1; req = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            n_checks++; if (frame_tick !== 1'b0 || gnt !== 4'b0000) begin n_fail++; $display("FAIL no_open_after_reset: got ft=%b gnt=%b want 0 0000", frame_tick, gnt); end
        end
        req = 4'b0000;
        start_frame();
        n_checks++; if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL first_tick: got %b want 1", frame_tick); end
        n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL first_frame_cnt: got %0d want 1", frame_cnt); end
        n_checks++; if (window_open !== 1'b1) begin n_fail++; $display("FAIL first_window: got %b want 1", window_open); end
        tick(1);
        n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL tick_single: got %b want 0", frame_tick); end
        end_frame();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        req = 4'b1111;
        start_frame();
        n_checks++; if (frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL rr_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
        for (int i = 0; i < 4; i++) begin
            exp = 4'b0001 << i;
            tick(1);
            n_checks++; if (gnt !== exp) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", i, gnt, exp); end
            tick(9);
            done = exp;
            tick(1);
            done = 4'b0000;
            n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rr_release%0d: got %b want 0000", i, gnt); end
        end
        for (int i = 0; i < 5; i++) begin
            tick(1);
            n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rr_served_once: got %b want 0000", gnt); end
        end
        end_frame();
        n_checks++; if (missed !== 4'b0000) begin n_fail++; $display("FAIL rr_missed: got %b want 0000", missed); end
        start_frame();
        tick(1);
        n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rr_wrap: got %b want 0001", gnt); end
        done = 4'b0001; req = 4'b0000;
        tick(1);
        done = 4'b0000;
        end_frame();
    endtask

    task automatic test_timeout();
        int held = 1;
        logic released = 1'b0;
        req = 4'b0100;
        start_frame();
        tick(1);
        n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL to_grant: got %b want 0100", gnt); end
        for (int c = 0; c < 5000 && !released; c++) begin
            tick(1);
            if (gnt === 4'b0100) held++;
            else released = 1'b1;
        end
        n_checks++; if (held !== 4096) begin n_fail++; $display("FAIL to_hold_len: got %0d cycles want 4096", held); end
        n_checks++; if (overrun !== 1'b1 || ovr_id !== 2'd2) begin n_fail++; $display("FAIL to_overrun: got ov=%b id=%0d want 1 2", overrun, ovr_id); end
        for (int i = 0; i < 6; i++) begin
            tick(1);
            n_checks++; if (gnt !== 4'b0000 || overrun !== 1'b0) begin n_fail++; $display("FAIL to_no_regrant: got gnt=%b ov=%b want 0000 0", gnt, overrun); end
        end
        end_frame();
        n_checks++; if (missed !== 4'b0000) begin n_fail++; $display("FAIL to_missed: got %b want 0000", missed); end
        req = 4'b0000;
    endtask

    task automatic test_pointer();
        logic [3:0] seq [3] = '{4'b1000, 4'b0001, 4'b0010};
        req = 4'b1011;
        start_frame();
        for (int i = 0; i < 3; i++) begin
            tick(1);
            n_checks++; if (gnt !== seq[i]) begin n_fail++; $display("FAIL ptr_order%0d: got %b want %b", i, gnt, seq[i]); end
            tick(2);
            done = seq[i];
            tick(1);
            done = 4'b0000;
        end
        req = 4'b0000;
        end_frame();
    endtask

    task automatic test_guard();
        start_frame();
        tick(1);
        vcount = 11'd804; req = 4'b0001;
        tick(1);
        n_checks++; if (window_open !== 1'b0) begin n_fail++; $display("FAIL guard_window: got %b want 0", window_open); end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL guard_no_grant: got %b want 0000", gnt); end
            tick(1);
            vcount = 11'd805;
        end
        end_frame();
        n_checks++; if (missed !== 4'b0001) begin n_fail++; $display("FAIL guard_missed: got %b want 0001", missed); end
        req = 4'b0000;
    endtask

    task automatic test_vblank_cut();
        req = 4'b0010;
        start_frame();
        tick(1);
        n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL cut_grant: got %b want 0010", gnt); end
        tick(5);
        vblnk = 1'b0; vcount = 11'd0;
        tick(1);
        n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL cut_release: got %b want 0000", gnt); end
        n_checks++; if (overrun !== 1'b1 || ovr_id !== 2'd1) begin n_fail++; $display("FAIL cut_overrun: got ov=%b id=%0d want 1 1", overrun, ovr_id); end
        tick(1);
        n_checks++; if (overrun !== 1'b0 || missed !== 4'b0000) begin n_fail++; $display("FAIL cut_close: got ov=%b missed=%b want 0 0000", overrun, missed); end
        req = 4'b0000;
        tick(2);
        n_checks++; if (gnt !== 4'b0000 || window_open !== 1'b0) begin n_fail++; $display("FAIL cut_idle: got gnt=%b wo=%b want 0000 0", gnt, window_open); end
    endtask

    task automatic test_done_priority();
        req = 4'b0001;
        start_frame();
        tick(1);
        n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL prio_grant: got %b want 0001", gnt); end
        done = 4'b1000;
        tick(1);
        done = 4'b0000;
        n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL prio_spurious: got %b want 0001", gnt); end
        tick(4094);
        n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL prio_still_held: got %b want 0001", gnt); end
        done = 4'b0001;
        tick(1);
        done = 4'b0000;
        n_checks++; if (gnt !== 4'b0000 || overrun !== 1'b0) begin n_fail++; $display("FAIL prio_release: got gnt=%b ov=%b want 0000 0", gnt, overrun); end
        tick(1);
        n_checks++; if (gnt !== 4'b0000 || overrun !== 1'b0) begin n_fail++; $display("FAIL prio_after: got gnt=%b ov=%b want 0000 0", gnt, overrun); end
        end_frame();
        n_checks++; if (missed !== 4'b0000) begin n_fail++; $display("FAIL prio_missed: got %b want 0000", missed); end
    endtask

    task automatic test_reset_midgrant();
        req = 4'b0001;
        start_frame();
        n_checks++; if (frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL mid_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
        tick(1);
        n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL mid_grant: got %b want 0001", gnt); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL mid_async_drop: got %b want 0000", gnt); end
        n_checks++; if (frame_cnt !== 16'd0 || window_open !== 1'b0) begin n_fail++; $display("FAIL mid_state: got cnt=%0d wo=%b want 0 0", frame_cnt, window_open); end
        tick(1);
        rst = 1'b1;
        tick(3);
        n_checks++; if (gnt !== 4'b0000 || frame_tick !== 1'b0) begin n_fail++; $display("FAIL mid_no_reopen: got gnt=%b ft=%b want 0000 0", gnt, frame_tick); end
        req = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_timeout();
        test_pointer();
        test_guard();
        test_vblank_cut();
        test_done_priority();
        test_reset_midgrant();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
